// File: rtl/axis_bist_gen.sv
// axis_bist_gen: AXI4-Stream BIST packet generator.
// Emits NUM_PKTS packets of PKT_LEN beats from a deterministic pattern,
// with GAP_CYCLES idle cycles between packets, and reports BUSY/DONE and
// a saturating accepted-beat count.
// Optional macro BIST_LFSR_EN: replaces the incrementing-counter pattern
// with a 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1); requires a 16-bit
// data width.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no run in progress, TVALID low, waiting for START
// SEND  | TVALID high, presenting beats of the current packet
// GAP   | TVALID low between packets, gap down-counter running
module axis_bist_gen #(
  parameter int C_M_AXIS_TDATA_WIDTH = 16,
  parameter int PKT_LEN              = 32,
  parameter int NUM_PKTS             = 4,
  parameter int GAP_CYCLES           = 2
) (
  input  logic                            S_AXIS_ACLK,
  input  logic                            S_AXIS_ARESETN,
  input  logic                            START,
  input  logic                            STOP,
  input  logic [C_M_AXIS_TDATA_WIDTH-1:0] SEED,
  input  logic                            M_AXIS_TREADY,
  output logic                            M_AXIS_TVALID,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                            M_AXIS_TLAST,
  output logic                            BUSY,
  output logic                            DONE,
  output logic [31:0]                     BEAT_COUNT
);

  localparam int DW = C_M_AXIS_TDATA_WIDTH;
  localparam int BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam int PW = (NUM_PKTS > 1) ? $clog2(NUM_PKTS) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [BW-1:0] BEAT_LAST = BW'(PKT_LEN - 1);
  localparam logic [PW-1:0] PKT_FINAL = PW'(NUM_PKTS - 1);
  localparam logic [GW-1:0] GAP_LOAD  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic          LAST_ON_FIRST = (PKT_LEN == 1);

  if (PKT_LEN < 1 || NUM_PKTS < 1) begin : g_param_chk
    $error("axis_bist_gen: PKT_LEN and NUM_PKTS must both be >= 1");
  end

`ifdef BIST_LFSR_EN
  if (DW != 16) begin : g_lfsr_width_chk
    $error("axis_bist_gen: BIST_LFSR_EN requires C_M_AXIS_TDATA_WIDTH == 16");
  end

  // Fibonacci LFSR, shift left, taps 16/14/13/11 fed back into bit 0.
  function automatic logic [DW-1:0] pat_next(input logic [DW-1:0] cur);
    return {cur[DW-2:0], cur[15] ^ cur[13] ^ cur[12] ^ cur[10]};
  endfunction

  // The all-zero state would lock the LFSR, so substitute 1.
  function automatic logic [DW-1:0] pat_seed(input logic [DW-1:0] s);
    return (s == '0) ? DW'(1) : s;
  endfunction
`else
  function automatic logic [DW-1:0] pat_next(input logic [DW-1:0] cur);
    return cur + DW'(1);
  endfunction

  function automatic logic [DW-1:0] pat_seed(input logic [DW-1:0] s);
    return s;
  endfunction
`endif

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  state_t          state_q,  state_d;
  logic            tvalid_q, tvalid_d;
  logic            tlast_q,  tlast_d;
  logic [DW-1:0]   tdata_q,  tdata_d;
  logic            busy_q,   busy_d;
  logic            done_q,   done_d;
  logic [31:0]     bc_q,     bc_d;
  logic [BW-1:0]   beat_q,   beat_d;
  logic [PW-1:0]   pkt_q,    pkt_d;
  logic [GW-1:0]   gap_q,    gap_d;
  logic            stop_q,   stop_d;

  logic hs;
  logic stop_eff;

  assign hs       = tvalid_q & M_AXIS_TREADY;
  // A STOP seen in the same cycle as the deciding edge counts immediately.
  assign stop_eff = stop_q | STOP;

  // Next-state and next-output computation for the whole controller.
  always_comb begin
    state_d  = state_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    tdata_d  = tdata_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    bc_d     = bc_q;
    beat_d   = beat_q;
    pkt_d    = pkt_q;
    gap_d    = gap_q;
    stop_d   = stop_q;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          tdata_d  = pat_seed(SEED);
          beat_d   = '0;
          pkt_d    = '0;
          bc_d     = '0;
          stop_d   = STOP;
          busy_d   = 1'b1;
          tvalid_d = 1'b1;
          tlast_d  = LAST_ON_FIRST;
          state_d  = S_SEND;
        end
      end

      S_SEND: begin
        stop_d = stop_eff;
        if (hs) begin
          // tdata_q doubles as the pattern register, so it holds the next
          // value through a gap and the sequence stays continuous.
          tdata_d = pat_next(tdata_q);
          if (bc_q != '1) begin
            bc_d = bc_q + 32'd1;
          end
          if (tlast_q) begin
            beat_d = '0;
            pkt_d  = pkt_q + PW'(1);
            if (pkt_q == PKT_FINAL || stop_eff) begin
              state_d  = S_IDLE;
              tvalid_d = 1'b0;
              tlast_d  = 1'b0;
              busy_d   = 1'b0;
              done_d   = 1'b1;
            end else if (GAP_CYCLES == 0) begin
              tlast_d = LAST_ON_FIRST;
            end else begin
              state_d  = S_GAP;
              tvalid_d = 1'b0;
              tlast_d  = 1'b0;
              gap_d    = GAP_LOAD;
            end
          end else begin
            beat_d  = beat_q + BW'(1);
            tlast_d = ((beat_q + BW'(1)) == BEAT_LAST);
          end
        end
      end

      S_GAP: begin
        stop_d = stop_eff;
        if (stop_eff) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (gap_q == '0) begin
          state_d  = S_SEND;
          tvalid_d = 1'b1;
          tlast_d  = LAST_ON_FIRST;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end

      default: begin
        state_d  = S_IDLE;
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      state_q  <= S_IDLE;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      bc_q     <= '0;
      beat_q   <= '0;
      pkt_q    <= '0;
      gap_q    <= '0;
      stop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      tdata_q  <= tdata_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      bc_q     <= bc_d;
      beat_q   <= beat_d;
      pkt_q    <= pkt_d;
      gap_q    <= gap_d;
      stop_q   <= stop_d;
    end
  end

  assign M_AXIS_TVALID = tvalid_q;
  assign M_AXIS_TDATA  = tdata_q;
  assign M_AXIS_TLAST  = tlast_q;
  assign BUSY          = busy_q;
  assign DONE          = done_q;
  assign BEAT_COUNT    = bc_q;

endmodule

// File: doc/axis_bist_gen.md
Name: axis_bist_gen

Overview:
- AXI4-Stream master that generates built-in self-test packets.
- Drives the FIR input stream (TDATA/TVALID/TLAST, honouring TREADY) for on-chip test without an external source.
- Emits NUM_PKTS packets of PKT_LEN beats each from a deterministic pattern, with an idle gap between packets.
- Reports busy/done status and an accepted-beat count for the companion checker.

Parameters:
- C_M_AXIS_TDATA_WIDTH, 16: stream data width.
- PKT_LEN, 32: beats per packet; legal range >= 1.
- NUM_PKTS, 4: packets per run; legal range >= 1.
- GAP_CYCLES, 2: idle cycles between packets with TVALID low; 0 means back-to-back.

Ports:
- S_AXIS_ACLK  in  1  clock.
- S_AXIS_ARESETN  in  1  asynchronous reset, active low.
- START  in  1  single-cycle run request; ignored while BUSY=1.
- STOP  in  1  graceful abort request; applied at the next packet boundary.
- SEED  in  C_M_AXIS_TDATA_WIDTH  pattern start value, sampled when START is accepted.
- M_AXIS_TREADY  in  1  downstream ready.
- M_AXIS_TVALID  out  1  data valid.
- M_AXIS_TDATA  out  C_M_AXIS_TDATA_WIDTH  pattern data.
- M_AXIS_TLAST  out  1  last beat of packet.
- BUSY  out  1  run in progress.
- DONE  out  1  one-cycle pulse when a run ends.
- BEAT_COUNT  out  32  beats accepted since the last START; saturates at 2^32-1.

Behaviour:
- Reset (asynchronous, immediate): TVALID=0, TLAST=0, TDATA=0, BUSY=0, DONE=0, BEAT_COUNT=0, all counters 0, FSM=IDLE.
- Reset mid-packet drops TVALID at once; downstream shares the same reset, so this is accepted.
- Every output is registered; no combinational path from TREADY to any output.
- A beat transfers on a rising edge where TVALID=1 and TREADY=1.
- AXI hold rule: while TVALID=1 and TREADY=0, TDATA and TLAST stay stable; TVALID never drops before its handshake.
- FSM state IDLE:
  - TVALID=0.
  - On START: latch SEED into pattern register, clear beat/pkt counters and BEAT_COUNT, clear the stop flag, set BUSY=1, go to SEND.
  - First beat is valid the cycle after START is sampled (1-cycle latency), with TDATA=SEED.
- FSM state SEND:
  - TVALID=1.
  - On each handshake: pattern advances, beat_cnt increments, BEAT_COUNT increments.
  - TLAST=1 exactly when beat_cnt==PKT_LEN-1; PKT_LEN=1 gives TLAST on every beat.
  - On handshake of the TLAST beat: beat_cnt wraps to 0 and pkt_cnt increments.
  - After the TLAST handshake, if pkt_cnt==NUM_PKTS-1 or the stop flag is set: go to IDLE, BUSY=0, DONE=1 for one cycle.
  - Otherwise, if GAP_CYCLES==0: stay in SEND, next beat presented on the following cycle.
  - Otherwise: go to GAP.
- FSM state GAP:
  - TVALID=0; gap counter runs GAP_CYCLES cycles, then go to SEND.
  - If the stop flag is set on entry or during GAP: go to IDLE, DONE=1.
- STOP:
  - Asserting STOP in SEND or GAP sets a sticky stop flag; the current packet always completes with TLAST.
  - STOP in IDLE has no effect.
  - START and STOP in the same IDLE cycle: the run starts with the stop flag set, so exactly one packet is sent.
- START while BUSY=1 is ignored and SEED is not re-sampled.
- Pattern (default): incrementing counter, next = current+1 modulo 2^C_M_AXIS_TDATA_WIDTH. It is continuous across packets, so packet p beat k = SEED + p*PKT_LEN + k.
- DONE and a new START: DONE asserts in the cycle IDLE is entered. A START sampled in that same cycle is accepted.

Optional Feature:
- Macro: BIST_LFSR_EN.
- When defined:
  - Pattern is a 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1, shifting left with feedback into bit 0, advancing once per handshake.
  - SEED=0 is replaced by 16'h0001.
  - C_M_AXIS_TDATA_WIDTH must be 16; any other value raises an elaboration $error.
- When undefined: incrementing-counter pattern only, and no LFSR logic is synthesised.

Test Plan:
- Counter run, TREADY tied 1: PKT_LEN=4, NUM_PKTS=2, GAP_CYCLES=2, SEED=16'h0010, START pulse -> beats 0x10..0x13 (TLAST on 0x13), TVALID low 2 cycles, beats 0x14..0x17 (TLAST on 0x17), DONE pulse, BEAT_COUNT=8, BUSY low.
- Backpressure: TREADY toggling randomly (50%) -> TDATA/TLAST stable whenever TVALID=1 and TREADY=0, sequence identical to the first scenario, no beat lost or duplicated.
- Wrap and boundary: SEED=16'hFFFE, PKT_LEN=1, NUM_PKTS=3, GAP_CYCLES=0 -> beats 0xFFFE, 0xFFFF, 0x0000, each with TLAST, back-to-back, then DONE.
- STOP mid-packet: NUM_PKTS=4, PKT_LEN=8, STOP at beat 3 of packet 0 -> packet 0 completes with TLAST on its beat 7, no further TVALID, DONE pulse, BEAT_COUNT=8; a START during the run is ignored.
- Async reset mid-packet: assert S_AXIS_ARESETN low during beat 5 -> TVALID, BUSY, BEAT_COUNT go to 0 immediately; a new START after release restarts from the newly sampled SEED.
- BIST_LFSR_EN defined, SEED=0: first beats are 0x0001, then successive LFSR states; the first 65535 accepted beats are all distinct, and beat 65536 equals 0x0001.
